// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry constants for the cache blocks
package cache_pkg;

    localparam int WORD_W = 32;
    localparam int NWORDS = 4;
    localparam int TAG_W  = 27;
    localparam int LINE_W = NWORDS * WORD_W;

endpackage

// File: rtl/cache_word.sv
// rtl/cache_word.sv - one data word of a cache line: enable register with sync reset
module cache_word #(
    parameter int WORD_W = cache_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cache_line.sv
// rtl/cache_line.sv - one cache line: per-word data registers plus tag and valid
module cache_line #(
    parameter int WORD_W = cache_pkg::WORD_W,
    parameter int NWORDS = cache_pkg::NWORDS,
    parameter int TAG_W  = cache_pkg::TAG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NWORDS-1:0]        regWrite,
    input  logic                     hit,
    input  logic [NWORDS*WORD_W-1:0] writeData,
    output logic [NWORDS*WORD_W-1:0] outBus,
    input  logic [TAG_W-1:0]         tag,
    output logic [TAG_W-1:0]         outTag,
    output logic                     outValid
);

    logic fill;

    // Any written word on a miss allocates the line, even a partial fill.
    assign fill = !hit && (|regWrite);

    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        cache_word #(
            .WORD_W(WORD_W)
        ) u_word (
            .clk  (clk),
            .reset(reset),
            .en   (regWrite[i]),
            .d    (writeData[i*WORD_W +: WORD_W]),
            .q    (outBus[i*WORD_W +: WORD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outTag   <= '0;
            outValid <= 1'b0;
        end else if (fill) begin
            outTag   <= tag;
            outValid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_line.sv
// tb/tb_cache_line.sv - scoreboard bench for cache_line with directed vectors
module tb_cache_line;

    localparam int LW = cache_pkg::LINE_W;
    localparam int TW = cache_pkg::TAG_W;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    regWrite;
    logic          hit;
    logic [LW-1:0] writeData;
    logic [LW-1:0] outBus;
    logic [TW-1:0] tag;
    logic [TW-1:0] outTag;
    logic          outValid;

    typedef struct {
        logic [LW-1:0] bus;
        logic [TW-1:0] tg;
        logic          v;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic stim_done = 1'b0;

    always #5 clk = ~clk;

    cache_line dut (
        .clk      (clk),
        .reset    (reset),
        .regWrite (regWrite),
        .hit      (hit),
        .writeData(writeData),
        .outBus   (outBus),
        .tag      (tag),
        .outTag   (outTag),
        .outValid (outValid)
    );

    // Drive one edge's worth of inputs and queue what must be visible after that edge.
    task automatic step(input logic r, input logic [3:0] rw, input logic h,
                        input logic [LW-1:0] wd, input logic [TW-1:0] tg,
                        input logic [LW-1:0] e_bus, input logic [TW-1:0] e_tag,
                        input logic e_v, input string name);
        exp_t e;
        @(negedge clk);
        reset = r; regWrite = rw; hit = h; writeData = wd; tag = tg;
        e.bus = e_bus; e.tg = e_tag; e.v = e_v; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (outBus !== e.bus) begin
                    n_fail++;
                    $display("FAIL %s bus: got %h want %h", e.name, outBus, e.bus);
                end
                n_cmp++;
                if (outTag !== e.tg) begin
                    n_fail++;
                    $display("FAIL %s tag: got %h want %h", e.name, outTag, e.tg);
                end
                n_cmp++;
                if (outValid !== e.v) begin
                    n_fail++;
                    $display("FAIL %s valid: got %b want %b", e.name, outValid, e.v);
                end
            end
        end
    end

    localparam logic [LW-1:0] ONES  = {LW{1'b1}};
    localparam logic [LW-1:0] PAT   = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [LW-1:0] FIVES = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [LW-1:0] NINES = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
    localparam logic [LW-1:0] PAT_W1 = 128'h4444_4444_3333_3333_5555_5555_1111_1111;
    localparam logic [LW-1:0] PAT_W2 = 128'h4444_4444_9999_9999_5555_5555_1111_1111;

    initial begin
        reset = 1'b1; regWrite = '0; hit = 1'b0; writeData = '0; tag = '0;

        step(1'b1, 4'hF, 1'b0, ONES, 27'h1234567, '0, '0, 1'b0, "rst_over_fill");
        step(1'b0, 4'h0, 1'b1, ONES, 27'h7654321, '0, '0, 1'b0, "idle_after_rst");
        step(1'b0, 4'hF, 1'b0, 128'd128, 27'h0ABCDE, 128'd128, 27'h0ABCDE, 1'b1, "fill_128");
        step(1'b0, 4'hF, 1'b0, 128'd256, 27'h0000F1, 128'd256, 27'h0000F1, 1'b1, "fill_256");
        step(1'b0, 4'hF, 1'b1, 128'd200, 27'h7FFFFFF, 128'd200, 27'h0000F1, 1'b1, "hit_200");
        step(1'b0, 4'hF, 1'b1, PAT, 27'h0000000, PAT, 27'h0000F1, 1'b1, "hit_pattern");
        step(1'b0, 4'b0010, 1'b1, FIVES, 27'h0000ABC, PAT_W1, 27'h0000F1, 1'b1, "hit_word1");

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h0, i[0], NINES, TW'(i * 27'h111111 + 27'h5), PAT_W1, 27'h0000F1,
                 1'b1, "no_write_hold");
        end

        step(1'b0, 4'b0100, 1'b0, NINES, 27'h0000123, PAT_W2, 27'h0000123, 1'b1, "partial_fill");

        // A write pulse that is withdrawn before the edge must leave no trace.
        step(1'b0, 4'h0, 1'b1, '0, 27'h0000777, PAT_W2, 27'h0000123, 1'b1, "mid_cycle_glitch");
        @(posedge clk);
        #2;
        regWrite = 4'hF; hit = 1'b0; writeData = ONES; tag = 27'h3333333;
        #2;
        regWrite = 4'h0;
        step(1'b0, 4'h0, 1'b0, ONES, 27'h3333333, PAT_W2, 27'h0000123, 1'b1, "after_glitch");

        step(1'b1, 4'hF, 1'b0, ONES, 27'h2222222, '0, '0, 1'b0, "rst_over_valid");
        step(1'b0, 4'h0, 1'b0, ONES, 27'h2222222, '0, '0, 1'b0, "zero_until_write");
        step(1'b0, 4'h0, 1'b1, ONES, 27'h1111111, '0, '0, 1'b0, "zero_until_write2");

        @(negedge clk);
        regWrite = '0;
        stim_done = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
